// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset beats flush, flush beats stall, stall beats load.
// A bubble carries a NOP with valid cleared and keeps the previous PC fields.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  stall_i,
    input  logic                  load_i,
    input  logic                  bubble_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o,
    output logic                  valid_o
);

    localparam logic [DATA_WIDTH-1:0] Nop = DATA_WIDTH'(NOP_INSTR);

    logic [DATA_WIDTH-1:0] instr_q, pc_q, pc_plus4_q;
    logic                  valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q    <= Nop;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            instr_q <= Nop;
            valid_q <= 1'b0;
        end else if (!stall_i) begin
            if (load_i) begin
                instr_q    <= instr_i;
                pc_q       <= pc_i;
                pc_plus4_q <= pc_i + DATA_WIDTH'(4);
                valid_q    <= 1'b1;
            end else if (bubble_i) begin
                instr_q <= Nop;
                valid_q <= 1'b0;
            end
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC, one-outstanding imem requests, skid buffer and IF/ID register.
// Define FETCH_PERF_EN to add the FetchCountF / FetchBubbleCountF performance counters.
module fetch
    import fetch_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    input  logic                  StallD,
    input  logic                  FlushD,
    output logic                  ImemReqF,
    output logic [DATA_WIDTH-1:0] ImemAddrF,
    input  logic                  ImemValidF,
    input  logic [DATA_WIDTH-1:0] ImemRdataF,
    output logic [DATA_WIDTH-1:0] instrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           FetchCountF,
    output logic [31:0]           FetchBubbleCountF
`endif
);

    localparam logic [DATA_WIDTH-1:0] Four = DATA_WIDTH'(4);

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pcf_q, pcf_d;
    logic [DATA_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [DATA_WIDTH-1:0] skid_pc_q, skid_pc_d;

    logic                  load, bubble, miss_bubble;
    logic [DATA_WIDTH-1:0] load_instr, load_pc;

    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        pend_pc_d    = pend_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        load         = 1'b0;
        bubble       = 1'b0;
        miss_bubble  = 1'b0;
        load_instr   = ImemRdataF;
        load_pc      = pcf_q;
        ImemReqF     = 1'b0;
        ImemAddrF    = pcf_q;

        unique case (state_q)
            FETCH: begin
                ImemReqF = 1'b1;
                if (ImemValidF) begin
                    if (PCSrcE) begin
                        pcf_d  = PCTargetE;
                        bubble = 1'b1;
                    end else if (!StallD) begin
                        load  = 1'b1;
                        pcf_d = pcf_q + Four;
                    end else begin
                        skid_instr_d = ImemRdataF;
                        skid_pc_d    = pcf_q;
                        state_d      = HOLD;
                    end
                end else begin
                    bubble      = 1'b1;
                    miss_bubble = 1'b1;
                    if (PCSrcE) begin
                        pend_pc_d = PCTargetE;
                        state_d   = DROP;
                    end
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    pcf_d   = PCTargetE;
                    bubble  = 1'b1;
                    state_d = FETCH;
                end else if (!StallD) begin
                    load       = 1'b1;
                    load_instr = skid_instr_q;
                    load_pc    = skid_pc_q;
                    pcf_d      = skid_pc_q + Four;
                    state_d    = FETCH;
                end
            end
            DROP: begin
                // Request stays on the old address until its response drains.
                ImemReqF = 1'b1;
                bubble   = 1'b1;
                if (PCSrcE) begin
                    pend_pc_d = PCTargetE;
                end
                if (ImemValidF) begin
                    pcf_d   = PCSrcE ? PCTargetE : pend_pc_q;
                    state_d = FETCH;
                end else begin
                    miss_bubble = 1'b1;
                end
            end
            default: state_d = FETCH;
        endcase

        if (rst) begin
            ImemReqF = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pcf_q        <= RESET_PC;
            pend_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            pend_pc_q    <= pend_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    if_id_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_if_id (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (FlushD),
        .stall_i    (StallD),
        .load_i     (load),
        .bubble_i   (bubble),
        .instr_i    (load_instr),
        .pc_i       (load_pc),
        .instr_o    (instrD),
        .pc_o       (PCD),
        .pc_plus4_o (PCPlus4D),
        .valid_o    (ValidD)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else if (!FlushD && !StallD) begin
            if (load) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end else if (miss_bubble) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign FetchCountF       = fetch_cnt_q;
    assign FetchBubbleCountF = bubble_cnt_q;
`else
    logic unused_miss_bubble;
    assign unused_miss_bubble = miss_bubble;
`endif

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: behavioural variable-latency memory plus an in-order program-stream model.
module tb_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrcE, StallD, FlushD;
    logic [31:0] PCTargetE;
    logic        ImemReqF, ImemValidF;
    logic [31:0] ImemAddrF, ImemRdataF;
    logic [31:0] instrD, PCD, PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_EN
    logic [31:0] FetchCountF, FetchBubbleCountF;
`endif

    fetch #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .ImemReqF  (ImemReqF),
        .ImemAddrF (ImemAddrF),
        .ImemValidF(ImemValidF),
        .ImemRdataF(ImemRdataF),
        .instrD    (instrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
`ifdef FETCH_PERF_EN
        ,
        .FetchCountF      (FetchCountF),
        .FetchBubbleCountF(FetchBubbleCountF)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model state
    bit          outst = 0;
    logic [31:0] oaddr = '0;
    int          rem = 0;
    int          max_lat = 0;
    bit          fixed_lat = 1;

    // Program-stream model state
    logic [31:0] exp_pc = '0;
    int          delivered = 0;
    int          bubbles = 0;
    int          last_gap = 0;
    bit          got_valid = 0;
    logic [31:0] prev_instr = NOP, prev_pcd = '0, prev_pcp4 = '0;
    logic        prev_valid = 1'b0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        PCSrcE = 1'b0;
        FlushD = 1'b0;
        StallD = 1'b0;
        PCTargetE = '0;
    endtask

    // One clock: answer the request, take the edge, then check the IF/ID result.
    task automatic step();
        logic        rs, wr, fl, rd, gave;
        logic [31:0] tgt;
        rs = rst;
        gave = 1'b0;
        ImemValidF = 1'b0;
        ImemRdataF = '0;
        if (!rs && ImemReqF) begin
            if (!outst) begin
                outst = 1;
                oaddr = ImemAddrF;
                rem = fixed_lat ? max_lat : $urandom_range(0, max_lat);
            end else begin
                chk("addr_stable", ImemAddrF, oaddr);
            end
            if (rem == 0) begin
                ImemValidF = 1'b1;
                ImemRdataF = word_at(oaddr);
                gave = 1'b1;
            end else begin
                rem--;
            end
        end
        wr = !StallD && !FlushD;
        fl = FlushD;
        rd = PCSrcE;
        tgt = PCTargetE;
        @(posedge clk);
        #1;
        ImemValidF = 1'b0;
        if (gave || rs) outst = 0;
        got_valid = 0;
        if (rs) begin
            chk("rst_req", 32'(ImemReqF), 32'd0);
            chk("rst_valid", 32'(ValidD), 32'd0);
            chk("rst_instr", instrD, NOP);
            chk("rst_pcd", PCD, 32'd0);
            chk("rst_pcp4", PCPlus4D, 32'd0);
            exp_pc = 32'd0;
            bubbles = 0;
        end else if (fl) begin
            chk("flush_valid", 32'(ValidD), 32'd0);
            chk("flush_instr", instrD, NOP);
            chk("flush_pcd", PCD, prev_pcd);
        end else if (!wr) begin
            chk("hold_instr", instrD, prev_instr);
            chk("hold_pcd", PCD, prev_pcd);
            chk("hold_valid", 32'(ValidD), 32'(prev_valid));
        end else if (ValidD) begin
            chk("stream_pc", PCD, exp_pc);
            chk("stream_instr", instrD, word_at(exp_pc));
            chk("stream_pcp4", PCPlus4D, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            delivered++;
            last_gap = bubbles;
            bubbles = 0;
            got_valid = 1;
        end else begin
            chk("bubble_instr", instrD, NOP);
            chk("bubble_pcd", PCD, prev_pcd);
            bubbles++;
        end
        if (rd && !rs) exp_pc = tgt;
        prev_instr = instrD;
        prev_pcd = PCD;
        prev_pcp4 = PCPlus4D;
        prev_valid = ValidD;
    endtask

    initial begin
        bit found;
        int first;
        rst = 1'b1;
        ImemValidF = 1'b0;
        ImemRdataF = '0;
        idle_inputs();

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("first_req", 32'(ImemReqF), 32'd1);
        chk("first_addr", ImemAddrF, 32'd0);

        // Zero-wait memory: one instruction per cycle, addresses 0,4,8..
        max_lat = 0;
        fixed_lat = 1;
        for (int i = 0; i < 4; i++) begin
            chk("zw_addr", ImemAddrF, 32'(i * 4));
            step();
            chk("zw_valid", 32'(ValidD), 32'd1);
        end

        // Stall while the response at 0x10 returns
        chk("pre_stall_addr", ImemAddrF, 32'h10);
        StallD = 1'b1;
        step();
        chk("hold_req0", 32'(ImemReqF), 32'd0);
        step();
        chk("hold_req1", 32'(ImemReqF), 32'd0);
        StallD = 1'b0;
        step();
        chk("skid_pcd", PCD, 32'h10);
        chk("post_hold_req", 32'(ImemReqF), 32'd1);
        chk("post_hold_addr", ImemAddrF, 32'h14);

        // Three-cycle latency: two bubbles between consecutive instructions
        max_lat = 2;
        first = 1;
        for (int i = 0; i < 15; i++) begin
            step();
            if (got_valid) begin
                if (!first) chk("lat3_gap", 32'(last_gap), 32'd2);
                first = 0;
            end
        end

        // Redirect while a response is outstanding: DROP, then target
        max_lat = 3;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (outst && rem > 0) found = 1;
        end
        chk("drop_setup", 32'(found), 32'd1);
        PCSrcE = 1'b1;
        FlushD = 1'b1;
        PCTargetE = 32'h100;
        step();
        idle_inputs();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            found = outst && rem == 0;
            step();
        end
        chk("drop_drain", 32'(found), 32'd1);
        chk("drop_target_addr", ImemAddrF, 32'h100);
        max_lat = 0;
        for (int i = 0; i < 3; i++) step();

        // Flush together with stall and a valid response
        StallD = 1'b1;
        FlushD = 1'b1;
        PCSrcE = 1'b1;
        PCTargetE = 32'h200;
        step();
        chk("flush_stall_valid", 32'(ValidD), 32'd0);
        idle_inputs();
        step();
        chk("flush_redirect_addr", ImemAddrF, 32'h204);

        // PC wrap at the top of the address space
        PCSrcE = 1'b1;
        FlushD = 1'b1;
        PCTargetE = 32'hFFFF_FFF8;
        step();
        idle_inputs();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (ValidD && PCD == 32'hFFFF_FFFC) found = 1;
        end
        chk("wrap_seen", 32'(found), 32'd1);
        chk("wrap_pcp4", PCPlus4D, 32'd0);
        chk("wrap_addr", ImemAddrF, 32'd0);

        // Reset in the middle of an outstanding request
        max_lat = 3;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rerst_addr", ImemAddrF, 32'd0);

        // Randomised traffic
        fixed_lat = 0;
        first = delivered;
        for (int i = 0; i < 2000; i++) begin
            StallD = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) begin
                PCSrcE = 1'b1;
                FlushD = 1'b1;
                PCTargetE = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                                                         : 32'($urandom_range(0, 1023)) << 2;
            end else begin
                PCSrcE = 1'b0;
                FlushD = 1'b0;
            end
            step();
        end
        idle_inputs();
        chk("rand_progress", 32'(delivered - first > 200), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the pipelined core: owns the program counter, issues one-outstanding requests to a variable-latency instruction memory, and drives the IF/ID pipeline register that feeds `decode`. It applies taken branches and jumps from execute (`PCSrcE`/`PCTargetE`), honours hazard-unit stall/flush, and inserts NOP bubbles whenever no fetched instruction is ready.

## Interface
Parameters:
- `DATA_WIDTH`, 32, instruction/PC width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `PCSrcE`  in  1  redirect: a taken branch/jump resolved in execute
- `PCTargetE`  in  32  redirect target
- `StallD`  in  1  hold the IF/ID register
- `FlushD`  in  1  load a bubble into the IF/ID register
- `ImemReqF`  out  1  request valid; held high until the response arrives
- `ImemAddrF`  out  32  request address; stable while `ImemReqF`=1
- `ImemValidF`  in  1  one-cycle response pulse for the outstanding request
- `ImemRdataF`  in  32  instruction word, valid with `ImemValidF`
- `instrD`  out  32  instruction to decode
- `PCD`  out  32  PC of `instrD`
- `PCPlus4D`  out  32  `PCD`+4
- `ValidD`  out  1  `instrD` is a real fetched instruction (0 = bubble)

## Operation
- Registers: `PCF`, `PendPC` (redirect target captured in DROP), skid buffer {`SkidInstr`, `SkidPC`}, IF/ID {`instrD`, `PCD`, `PCPlus4D`, `ValidD`}, 2-bit FSM.
- Bubble is `instrD`=32'h0000_0013 (addi x0,x0,0), `ValidD`=0; `PCD`/`PCPlus4D` hold their previous values.
- FETCH: `ImemReqF`=1, `ImemAddrF`=`PCF`.
  - `ImemValidF` & `PCSrcE`: discard data; `PCF`<=`PCTargetE`; stay.
  - `ImemValidF` & !`StallD`: IF/ID <= {data, `PCF`, `PCF`+4, 1}; `PCF`<=`PCF`+4.
  - `ImemValidF` & `StallD`: skid <= {data, `PCF`}; go HOLD.
  - No `ImemValidF`, `PCSrcE`: `PendPC`<=`PCTargetE`; go DROP.
  - No `ImemValidF`, !`StallD`: IF/ID <= bubble.
- HOLD: `ImemReqF`=0. `PCSrcE`: drop skid, `PCF`<=`PCTargetE`, go FETCH. Else !`StallD`: IF/ID <= {`SkidInstr`, `SkidPC`, `SkidPC`+4, 1}, `PCF`<=`SkidPC`+4, go FETCH.
- DROP: `ImemReqF`=1, `ImemAddrF`=`PCF` (old address, unchanged). A further `PCSrcE` overwrites `PendPC`. On `ImemValidF`: discard data, `PCF`<=`PendPC` (or `PCTargetE` if `PCSrcE` is high that cycle), go FETCH. Drives bubbles into IF/ID when !`StallD`.
- IF/ID priority: `rst` > `FlushD` (bubble) > `StallD` (hold) > load. `FlushD` overrides any load above; the consumed word is lost, and the hazard unit asserts `FlushD` only together with `PCSrcE`.
- PC arithmetic is modulo 2^32; `PCF`+4 wraps at 32'hFFFF_FFFC to 0.

## Timing
- Reset: `PCF`=`RESET_PC`, FSM=FETCH, `ImemReqF`=0 during reset, skid/`PendPC`=0, IF/ID = {32'h13, 0, 0, 0}. The first request is issued the cycle after `rst` falls.
- Zero-wait memory (`ImemValidF` in the request cycle): one instruction per cycle; `instrD` is valid the cycle after the response.
- A redirect in cycle N puts `PCTargetE` on `ImemAddrF` in cycle N+1 (FETCH/HOLD), or the cycle after the pending response (DROP).
- `rst` mid-request: the FSM returns to FETCH immediately. The memory must abandon any outstanding response on `rst`.
- At most one request is outstanding; `ImemValidF` is never expected when `ImemReqF`=0.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `FetchCountF` [31:0] (increments on each IF/ID load with `ValidD`=1) and `FetchBubbleCountF` [31:0] (increments on each bubble load caused by a missing response). Both reset to 0 and wrap.
- Undefined: the ports and counters are absent.

## Structure
- `fetch_pkg`: `NOP_INSTR` constant (32'h0000_0013) and the FSM enum `fetch_state_t` {FETCH, HOLD, DROP}.
- Sub-module `if_id_reg`: the IF/ID register with the rst/flush/stall/load priority.

## Test plan
- Reset, `ImemValidF` tied to `ImemReqF`: `ImemAddrF` = 0, 4, 8…; `PCD` follows one cycle later with `ValidD`=1.
- 3-cycle memory latency: two bubbles (`instrD`=0x13, `ValidD`=0) between consecutive valid instructions.
- `StallD` high for 2 cycles as the response at PC 0x10 returns: HOLD with `ImemReqF`=0; 0x10 reaches `instrD` after release, then 0x14 is requested.
- `PCSrcE`=1, `PCTargetE`=0x100 while a response is outstanding: DROP; the late data is discarded and `ImemAddrF`=0x100 next. No instruction from the old path reaches `instrD`.
- `FlushD` and `StallD` asserted together with a valid response: IF/ID becomes a bubble.
- `PCF`=0xFFFF_FFFC fetched: the next address is 0x0 and `PCPlus4D`=0x0.
